// File: rtl/tpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpu_pkg: shared load-stage types and widths for the convolution TPU.
// Rev 1.0
// ---------------------------------------------------------------------------
package tpu_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MATRIX_DIM = 16;
  localparam int DEF_CONV_DIM   = 3;

  localparam int CONV_AW = $clog2(DEF_CONV_DIM);
  localparam int MAT_AW  = $clog2(DEF_MATRIX_DIM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    LOAD_M = 2'd2
  } load_state_t;

  typedef struct packed {
    logic [CONV_AW-1:0] row;
    logic [CONV_AW-1:0] col;
  } conv_coord_t;

  typedef struct packed {
    logic [MAT_AW-1:0] row;
    logic [MAT_AW-1:0] col;
  } base_coord_t;

endpackage
`default_nettype wire

// File: rtl/tpu_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpu_loader_if: command, byte-stream and SRAM write-port bundle of the loader.
// Rev 1.0
// ---------------------------------------------------------------------------
interface tpu_loader_if #(
  parameter int DATA_WIDTH = tpu_pkg::DEF_DATA_WIDTH,
  parameter int MATRIX_DIM = tpu_pkg::DEF_MATRIX_DIM,
  parameter int CONV_DIM   = tpu_pkg::DEF_CONV_DIM
);
  logic                          insert_kernel;
  logic                          insert_matrix;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH-1:0]         data_in;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [CONV_DIM-1:0]           kernel_we;
  logic [$clog2(CONV_DIM)-1:0]   kernel_addr;
  logic [MATRIX_DIM-1:0]         matrix_we;
  logic [$clog2(MATRIX_DIM)-1:0] matrix_addr;
  logic                          busy;
  logic                          kernel_loaded;
  logic                          matrix_loaded;
  logic                          load_done;
  logic                          cmd_err;

  modport master (
    output insert_kernel, insert_matrix, in_valid, data_in,
    input  in_ready, wr_data, kernel_we, kernel_addr, matrix_we, matrix_addr,
    input  busy, kernel_loaded, matrix_loaded, load_done, cmd_err
  );

  modport slave (
    input  insert_kernel, insert_matrix, in_valid, data_in,
    output in_ready, wr_data, kernel_we, kernel_addr, matrix_we, matrix_addr,
    output busy, kernel_loaded, matrix_loaded, load_done, cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/rowcol_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rowcol_counter: row-major col/row walker with a runtime wrap limit.
// Rev 1.0
// ---------------------------------------------------------------------------
module rowcol_counter (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic [tpu_pkg::MAT_AW-1:0] limit,
  output logic [tpu_pkg::MAT_AW-1:0] col,
  output logic [tpu_pkg::MAT_AW-1:0] row,
  output logic                       last
);
  import tpu_pkg::*;

  base_coord_t r_pos;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pos <= '0;
    end else if (clr) begin
      r_pos <= '0;
    end else if (en) begin
      if (r_pos.col == limit) begin
        r_pos.col <= '0;
        r_pos.row <= r_pos.row + 1'b1;
      end else begin
        r_pos.col <= r_pos.col + 1'b1;
      end
    end
  end

  assign col  = r_pos.col;
  assign row  = r_pos.row;
  assign last = (r_pos.col == limit) && (r_pos.row == limit);

endmodule
`default_nettype wire

// File: rtl/tpu_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tpu_loader: scatters a byte stream row-major into banked kernel/matrix SRAMs.
// Rev 1.0
// ---------------------------------------------------------------------------
module tpu_loader #(
  parameter int DATA_WIDTH = tpu_pkg::DEF_DATA_WIDTH,
  parameter int MATRIX_DIM = tpu_pkg::DEF_MATRIX_DIM,
  parameter int CONV_DIM   = tpu_pkg::DEF_CONV_DIM
) (
  input  logic        clk,
  input  logic        rst,
  tpu_loader_if.slave bus
);
  import tpu_pkg::*;

  localparam logic [CONV_DIM-1:0]   c_k_one = {{(CONV_DIM-1){1'b0}}, 1'b1};
  localparam logic [MATRIX_DIM-1:0] c_m_one = {{(MATRIX_DIM-1){1'b0}}, 1'b1};

  load_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [CONV_DIM-1:0]   r_kernel_we;
  logic [CONV_AW-1:0]    r_kernel_addr;
  logic [MATRIX_DIM-1:0] r_matrix_we;
  logic [MAT_AW-1:0]     r_matrix_addr;
  logic                  r_kernel_loaded;
  logic                  r_matrix_loaded;
  logic                  r_load_done;
  logic                  r_cmd_err;

  logic [MAT_AW-1:0]     w_col;
  logic [MAT_AW-1:0]     w_row;
  logic [MAT_AW-1:0]     w_limit;
  logic                  w_last;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_cmd;
  logic                  w_start;
  conv_coord_t           w_kpos;

  assign w_cmd      = bus.insert_kernel | bus.insert_matrix;
  assign w_start    = (r_state == IDLE) && w_cmd;
  assign w_in_ready = (r_state != IDLE);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_limit    = (r_state == LOAD_K) ? MAT_AW'(CONV_DIM - 1) : MAT_AW'(MATRIX_DIM - 1);
  assign w_kpos     = '{row: w_row[CONV_AW-1:0], col: w_col[CONV_AW-1:0]};

  rowcol_counter u_rowcol (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_start),
    .en    (w_accept),
    .limit (w_limit),
    .col   (w_col),
    .row   (w_row),
    .last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_wr_data       <= '0;
      r_kernel_we     <= '0;
      r_kernel_addr   <= '0;
      r_matrix_we     <= '0;
      r_matrix_addr   <= '0;
      r_kernel_loaded <= 1'b0;
      r_matrix_loaded <= 1'b0;
      r_load_done     <= 1'b0;
      r_cmd_err       <= 1'b0;
    end else begin
      r_kernel_we <= '0;
      r_matrix_we <= '0;
      r_load_done <= 1'b0;
      r_cmd_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          // Kernel command has priority; a simultaneous matrix command is flagged.
          if (bus.insert_kernel) begin
            r_state         <= LOAD_K;
            r_kernel_loaded <= 1'b0;
            r_cmd_err       <= bus.insert_matrix;
          end else if (bus.insert_matrix) begin
            r_state         <= LOAD_M;
            r_matrix_loaded <= 1'b0;
          end
        end
        LOAD_K, LOAD_M: begin
          if (w_cmd) begin
            r_cmd_err <= 1'b1;
          end
          if (w_accept) begin
            r_wr_data <= bus.data_in;
            if (r_state == LOAD_K) begin
              r_kernel_we   <= c_k_one << w_kpos.col;
              r_kernel_addr <= w_kpos.row;
            end else begin
              r_matrix_we   <= c_m_one << w_col;
              r_matrix_addr <= w_row;
            end
            if (w_last) begin
              r_state     <= IDLE;
              r_load_done <= 1'b1;
              if (r_state == LOAD_K) begin
                r_kernel_loaded <= 1'b1;
              end else begin
                r_matrix_loaded <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.busy          = w_in_ready;
  assign bus.wr_data       = r_wr_data;
  assign bus.kernel_we     = r_kernel_we;
  assign bus.kernel_addr   = r_kernel_addr;
  assign bus.matrix_we     = r_matrix_we;
  assign bus.matrix_addr   = r_matrix_addr;
  assign bus.kernel_loaded = r_kernel_loaded;
  assign bus.matrix_loaded = r_matrix_loaded;
  assign bus.load_done     = r_load_done;
  assign bus.cmd_err       = r_cmd_err;

endmodule
`default_nettype wire
